// File: rtl/bin_fb_reader.sv
// bin_fb_reader: streams a packed 1-bit-per-pixel framebuffer out of BRAM as raster pixels
// with valid/ready, one pixel per cycle, prefetching words through a credit-limited FIFO.
module bin_fb_reader #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int WORD_W     = 16,
  parameter int BRAM_LAT   = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int NW = WIDTH * HEIGHT / WORD_W,
  localparam int AW = $clog2(NW),
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int BW = $clog2(WORD_W),
  localparam int FW = $clog2(FIFO_DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  output logic              busy_out,
  output logic              done_out,
  output logic [AW-1:0]     addr_out,
  output logic              rd_en_out,
  input  logic [WORD_W-1:0] data_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [15:0]       pixel_out,
  output logic              bin_out,
  output logic [XW-1:0]     hcount_out,
  output logic [YW-1:0]     vcount_out,
  output logic              last_out
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [BRAM_LAT-1:0] in_flight;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [FW:0] count;
  logic [BW-1:0] bit_idx;
  logic push, hs, word_end;
  int n_flight;
  always_comb begin
    n_flight = 0;
    for (int i = 0; i < BRAM_LAT; i++) n_flight += int'(in_flight[i]);
  end
  // The FIFO head is the word being unpacked, so it counts against the read credit
  assign busy_out  = state != IDLE;
  assign rd_en_out = state == RUN && int'(count) + n_flight < FIFO_DEPTH;
  assign push      = in_flight[BRAM_LAT-1];
  assign valid_out = count != 0;
  assign hs        = valid_out && ready_in;
  assign word_end  = hs && bit_idx == BW'(WORD_W - 1);
  assign bin_out   = valid_out && mem[rd_ptr][bit_idx];
  assign pixel_out = {16{bin_out}};
  assign last_out  = valid_out && hcount_out == XW'(WIDTH - 1) && vcount_out == YW'(HEIGHT - 1);
  always_comb begin
    state_nx = (state == IDLE && start_in) ? RUN :
               (state == RUN && rd_en_out && addr_out == AW'(NW - 1)) ? DRAIN :
               (state == DRAIN && hs && last_out) ? IDLE : state;
  end
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= data_in;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      done_out   <= 1'b0;
      addr_out   <= '0;
      in_flight  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      bit_idx    <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
    end else begin
      state     <= state_nx;
      done_out  <= state == DRAIN && hs && last_out;
      in_flight <= (in_flight << 1) | BRAM_LAT'(rd_en_out);
      if (state == IDLE) begin
        if (start_in) begin
          addr_out   <= '0;
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          count      <= '0;
          bit_idx    <= '0;
          hcount_out <= '0;
          vcount_out <= '0;
        end
      end else begin
        if (rd_en_out && addr_out != AW'(NW - 1)) addr_out <= addr_out + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (word_end) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (FW+1)'(push) - (FW+1)'(word_end);
        if (hs) begin
          bit_idx    <= word_end ? '0 : bit_idx + 1'b1;
          hcount_out <= hcount_out == XW'(WIDTH - 1) ? '0 : hcount_out + 1'b1;
          vcount_out <= hcount_out != XW'(WIDTH - 1) ? vcount_out :
                        vcount_out == YW'(HEIGHT - 1) ? '0 : vcount_out + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/bin_fb_reader.md
# bin_fb_reader

Reads the packed 1-bit-per-pixel binarized framebuffer back out of BRAM and streams it as raster-ordered pixels with a valid/ready handshake. It is the consumer side of the binarization path: downstream QR finder/decoder logic and the debug display path pull frames from this block. Each stored bit is expanded to a 16-bit camera-format pixel, 0x0000 for 0 and 0xFFFF for 1. Every bit is tagged with its coordinates, and the block stays at one pixel per cycle under no backpressure.

## Interface
- WIDTH, 320: pixels per line
- HEIGHT, 240: lines per frame
- WORD_W, 16: BRAM word width in bits; WIDTH*HEIGHT must be a multiple of WORD_W
- BRAM_LAT, 2: cycles from rd_en_out high to matching data_in valid
- FIFO_DEPTH, 4: word prefetch buffer entries (power of two)
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous, active-low reset
- start_in  input  1  begin reading one frame; ignored while busy_out=1
- busy_out  output  1  high from the cycle after start accepted until done_out
- done_out  output  1  one-cycle pulse after the final pixel handshake
- addr_out  output  $clog2(WIDTH*HEIGHT/WORD_W)  BRAM word address
- rd_en_out  output  1  BRAM read strobe
- data_in  input  WORD_W  BRAM read data, valid BRAM_LAT cycles after rd_en_out
- valid_out  output  1  pixel outputs valid
- ready_in  input  1  downstream accepts the pixel
- pixel_out  output  16  0x0000 or 0xFFFF
- bin_out  output  1  raw stored bit
- hcount_out  output  $clog2(WIDTH)  x of the current pixel
- vcount_out  output  $clog2(HEIGHT)  y of the current pixel
- last_out  output  1  high with the final pixel of the frame (x=WIDTH-1, y=HEIGHT-1)

## Operation
- Pixel index p = y*WIDTH + x. The pixel lives in word p/WORD_W at bit p%WORD_W, LSB first.
- FSM:
  - IDLE: start_in=1 → RUN. Word address, pixel counters and FIFO are cleared.
  - RUN: issue reads at word addresses 0 … N-1, where N = WIDTH*HEIGHT/WORD_W.
    - A read is issued when (FIFO occupancy + reads in flight) < FIFO_DEPTH and words remain.
    - When the read of word N-1 is issued → DRAIN.
  - DRAIN: no reads are issued. The block waits for the final pixel handshake, then → IDLE and pulses done_out.
- Reads in flight are tracked by a BRAM_LAT-deep valid shift register. Returning data is always written into the FIFO; the credit rule guarantees space.
- Unpacker stage:
  - It holds one word and a bit index. It loads from the FIFO when it is empty, or when the last bit is consumed and the FIFO is non-empty.
  - A handshake is valid_out & ready_in. Each handshake advances the bit index, and x/y with wrap: x=WIDTH-1 → x=0, y+1.
  - Loading the next word in the same cycle as consuming bit WORD_W-1 is required (no bubble).
- When valid_out=1 and ready_in=0, pixel_out, bin_out, hcount_out, vcount_out and last_out hold stable.
- Pixel x/y counting is independent of word boundaries. WIDTH need not be a multiple of WORD_W.

## Timing
- Reset values: busy_out=0, done_out=0, addr_out=0, rd_en_out=0, valid_out=0, pixel_out=0, bin_out=0, hcount_out=0, vcount_out=0, last_out=0.
- Start accepted in cycle k:
  - rd_en_out=1 with addr_out=0 in cycle k+1.
  - First valid_out=1 in cycle k+BRAM_LAT+2.
- Throughput: one pixel per cycle while ready_in=1. rd_en_out duty settles at 1/WORD_W.
- Frame with ready_in tied high: last handshake in cycle k+BRAM_LAT+1+WIDTH*HEIGHT. done_out pulses in the following cycle, and busy_out falls in that same cycle.
- Backpressure: the credit rule stops reads once the FIFO plus reads in flight reach FIFO_DEPTH. No data is lost or overwritten.
- start_in asserted in the done_out cycle is accepted. start_in asserted while busy is dropped, not queued.
- rst_n_in low at any time:
  - All state clears immediately and asynchronously.
  - BRAM data returning after reset release is discarded, because the in-flight register is cleared.
- Counters use full width with explicit compare-to-limit wrap. There is no arithmetic overflow.

## Test plan
- Reset, then start with ready_in=1 and the BRAM model preloaded with 0xA5A5 everywhere. Required:
  - Pixel bits stream 1,0,1,0,0,1,0,1… LSB first, with pixel_out alternating 0xFFFF/0x0000.
  - Exactly 76800 handshakes occur, last_out=1 only at (319,239), and done_out fires once.
- Word address equal to its own index, WIDTH=20, HEIGHT=4: check x wraps at 19 with y incrementing mid-word, and that each bit matches the bit at p%16 of word p/16.
- Random ready_in (≈30% low): outputs stay stable while stalled, there are no duplicate or skipped pixels, and rd_en_out is never high when occupancy + in-flight = 4.
- ready_in held low for 100 cycles after start: exactly 4 reads are issued and then rd_en_out stays 0. After release, pixels resume in order.
- Start pulse while busy: ignored, and the frame count is unchanged. Start in the done_out cycle: a new frame begins with addr_out=0 in the next cycle.
- rst_n_in low mid-frame (pixel 1000), then released: all outputs read 0 immediately, stale BRAM returns produce no valid_out, and a fresh start produces a frame beginning at (0,0).
